// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - instruction field input handshake and imem write port
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - RV32I instruction encoder writing words sequentially into imem
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_encoder_loader_if.slave bus,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_ENC, S_WR, S_DONE, S_FULL} state_t;
  state_t state, state_nx;

  logic [2:0]        cls_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [2:0]        f3_q;
  logic              f7_q;
  logic [31:0]       imm_q;
  logic              last_q;
  logic [31:0]       word_q;
  logic              err_q;
  logic [ADDR_W-1:0] eaddr_q;
  logic [ADDR_W-1:0] ptr;

  logic        accept;
  logic        restart;
  logic        fits_i, fits_b, fits_j;
  logic        enc_ok;
  logic [31:0] enc_word;

  // start is refused mid-instruction so a pending write is never split from its pointer
  assign restart = start && (state != S_ENC) && (state != S_WR);
  assign accept  = (state == S_RUN) && bus.in_valid && !start;

  assign fits_i = ($signed(imm_q) >= -32'sd2048) && ($signed(imm_q) <= 32'sd2047);
  assign fits_b = ($signed(imm_q) >= -32'sd4096) && ($signed(imm_q) <= 32'sd4094) && !imm_q[0];
  assign fits_j = ($signed(imm_q) >= -32'sd1048576) && ($signed(imm_q) <= 32'sd1048574) && !imm_q[0];

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (cls_q)
      3'd0: begin
        enc_word = {imm_q[11:0], rs1_q, 3'b010, rd_q, OP_LW};
        enc_ok   = fits_i;
      end
      3'd1: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OP_SW};
        enc_ok   = fits_i;
      end
      3'd2: begin
        enc_word = {1'b0, f7_q, 5'b0, rs2_q, rs1_q, f3_q, rd_q, OP_RTYPE};
        enc_ok   = 1'b1;
      end
      3'd3: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1], imm_q[11], OP_BEQ};
        enc_ok   = fits_b;
      end
      3'd4: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_ITYPE};
        enc_ok   = fits_i;
      end
      3'd5: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_JAL};
        enc_ok   = fits_j;
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_FULL: if (start) state_nx = S_RUN;
      S_RUN: begin
        if (start)             state_nx = S_RUN;
        else if (bus.in_valid) state_nx = S_ENC;
      end
      S_ENC: begin
        if (enc_ok)      state_nx = S_WR;
        else if (last_q) state_nx = S_DONE;
        else             state_nx = S_RUN;
      end
      S_WR: begin
        if (last_q)                 state_nx = S_DONE;
        else if (ptr == LAST_ADDR)  state_nx = S_FULL;
        else                        state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      imm_q   <= '0;
      last_q  <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
      ptr     <= '0;
    end else begin
      if (restart) begin
        ptr     <= '0;
        err_q   <= 1'b0;
        eaddr_q <= '0;
      end
      if (accept) begin
        cls_q  <= bus.in_class;
        rd_q   <= bus.in_rd;
        rs1_q  <= bus.in_rs1;
        rs2_q  <= bus.in_rs2;
        f3_q   <= bus.in_funct3;
        f7_q   <= bus.in_funct7b5;
        imm_q  <= bus.in_imm;
        last_q <= bus.in_last;
      end
      if (state == S_ENC) begin
        if (enc_ok) begin
          word_q <= enc_word;
        end else begin
          err_q <= 1'b1;
          if (!err_q) eaddr_q <= ptr;
        end
      end
      // the last slot is terminal, so the pointer saturates instead of wrapping
      if (state == S_WR && ptr != LAST_ADDR) ptr <= ptr + 1'b1;
    end
  end

  // outputs are masked by rst_n so a reset during WR suppresses the strobe in that same cycle
  assign bus.in_ready   = rst_n && (state == S_RUN) && !start;
  assign bus.imem_we    = rst_n && (state == S_WR);
  assign bus.imem_waddr = bus.imem_we ? ptr : '0;
  assign bus.imem_wdata = bus.imem_we ? word_q : '0;
  assign done           = rst_n && (state == S_DONE);
  assign full           = rst_n && (state == S_FULL);
  assign err            = rst_n && err_q;
  assign err_addr       = rst_n ? eaddr_q : '0;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench with randomized programs and a reference encoder
module tb_instr_encoder_loader;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done, full, err;
  logic [AW-1:0] err_addr;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus();

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .done(done), .full(full), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  // reference state: 0 idle, 1 run, 2 done, 3 full
  int m_mode = 0;
  int m_ptr = 0;
  bit m_err = 0;
  int m_eaddr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit [32:0] ref_enc(input int cls, input int rd, input int rs1, input int rs2,
                                        input int f3, input int f7, input int imm);
    bit ok;
    bit [31:0] w;
    bit i_ok = (imm >= -2048) && (imm <= 2047);
    ok = 0;
    w = 0;
    case (cls)
      0: begin ok = i_ok; w = 32'('h03 + (rd << 7) + (2 << 12) + (rs1 << 15) + ((imm & 'hfff) << 20)); end
      1: begin ok = i_ok; w = 32'('h23 + ((imm & 31) << 7) + (2 << 12) + (rs1 << 15) + (rs2 << 20) + (((imm >>> 5) & 127) << 25)); end
      2: begin ok = 1; w = 32'('h33 + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 30)); end
      3: begin
        ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        w = 32'('h63 + (((imm >>> 11) & 1) << 7) + (((imm >>> 1) & 15) << 8) + (rs1 << 15) + (rs2 << 20)
                + (((imm >>> 5) & 63) << 25)) | (32'((imm >>> 12) & 1) << 31);
      end
      4: begin ok = i_ok; w = 32'('h13 + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 'hfff) << 20)); end
      5: begin
        ok = (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
        w = 32'('h6f + (rd << 7) + (((imm >>> 12) & 255) << 12) + (((imm >>> 11) & 1) << 20)
                + (((imm >>> 1) & 1023) << 21)) | (32'((imm >>> 20) & 1) << 31);
      end
      default: ok = 0;
    endcase
    return {ok, w};
  endfunction

  always @(negedge clk) begin
    if (bus.imem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("waddr", bus.imem_waddr, e.addr);
        check("wdata", bus.imem_wdata, e.data);
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_zero_ready"}, bus.in_ready, 0);
    check({tag, "_zero_we"}, bus.imem_we, 0);
    check({tag, "_zero_wbus"}, {bus.imem_waddr, bus.imem_wdata}, 0);
    check({tag, "_zero_flags"}, {done, full, err, err_addr}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_mode = 0; m_ptr = 0; m_err = 0; m_eaddr = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_mode = 1; m_ptr = 0; m_err = 0; m_eaddr = 0;
  endtask

  task automatic send(input int cls, input int rd, input int rs1, input int rs2, input int f3,
                      input int f7, input int imm, input bit last,
                      input bit use_exp = 0, input logic [31:0] exp_word = 0);
    int t;
    int acc;
    bit [32:0] r;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.in_class = 3'(cls); bus.in_rd = 5'(rd); bus.in_rs1 = 5'(rs1); bus.in_rs2 = 5'(rs2);
    bus.in_funct3 = 3'(f3); bus.in_funct7b5 = 1'(f7); bus.in_imm = 32'(imm); bus.in_last = last;
    bus.in_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    r = ref_enc(cls, rd, rs1, rs2, f3, f7, imm);
    if (r[32]) begin
      sb.push_back('{addr: m_ptr, data: use_exp ? exp_word : r[31:0], cyc: acc + 2});
      m_ptr++;
      if (last) m_mode = 2;
      else if (m_ptr == DEPTH) m_mode = 3;
    end else begin
      if (!m_err) m_eaddr = m_ptr;
      m_err = 1;
      if (last) m_mode = 2;
    end
  endtask

  task automatic settle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"}, done, m_mode == 2);
    check({tag, "_full"}, full, m_mode == 3);
    check({tag, "_ready"}, bus.in_ready, m_mode == 1);
    check({tag, "_err"}, err, m_err);
    if (m_err) check({tag, "_err_addr"}, err_addr, m_eaddr);
  endtask

  int imm_tab[16] = '{0, 5, -1, 2047, -2048, 2048, -2049, 4094, 4095, -4096, -4098,
                      1048574, -1048576, 1048576, 3, -7};

  function automatic int rand_imm();
    case ($urandom_range(0, 3))
      0, 1: return imm_tab[$urandom_range(0, 15)];
      2: return $urandom_range(0, 10000) - 5000;
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_class = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_funct3 = 0; bus.in_funct7b5 = 0; bus.in_imm = 0; bus.in_last = 0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    do_reset();

    do_start();
    send(4, 1, 0, 0, 0, 0, 5, 0, 1, 32'h00500093);
    settle();
    check_status("t1");

    do_start();
    send(2, 3, 1, 2, 0, 1, 0, 0, 1, 32'h402081B3);
    send(0, 5, 2, 0, 0, 0, 8, 0, 1, 32'h00812283);
    send(1, 0, 2, 5, 0, 0, 12, 0, 1, 32'h00512623);
    send(3, 0, 1, 2, 0, 0, -8, 0, 1, 32'hFE208CE3);
    send(5, 1, 0, 0, 0, 0, 16, 1, 1, 32'h010000EF);
    settle();
    check_status("t3");

    do_start();
    send(3, 0, 1, 2, 0, 0, 3, 0);
    send(7, 1, 1, 1, 0, 0, 0, 0);
    settle();
    check_status("t4a");
    send(4, 2, 0, 0, 0, 0, 1, 0, 1, 32'h00100113);
    settle();
    check_status("t4b");

    do_start();
    for (int i = 0; i < DEPTH; i++) send(4, i, 1, 0, 0, 0, i, 0);
    settle();
    check_status("t5_full");
    repeat (4) @(negedge clk);
    check_status("t5_hold");
    do_start();
    check("t5_full_clear", full, 0);
    send(2, 4, 5, 6, 7, 0, 0, 0);
    settle();

    do_start();
    send(4, 1, 0, 0, 0, 0, 5, 0);
    void'(sb.pop_back());
    rst_n = 1'b0;
    #1 check_zero("rst_enc");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_mode = 0; m_ptr = 0; m_err = 0; m_eaddr = 0;
    check_zero("rst_enc_after");
    do_start();
    send(4, 1, 0, 0, 0, 0, 5, 0);
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("rst_wr");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_mode = 0; m_ptr = 0; m_err = 0; m_eaddr = 0;
    do_start();
    send(4, 1, 0, 0, 0, 0, 5, 0, 1, 32'h00500093);
    settle();
    check_status("t6");

    for (int p = 0; p < 12; p++) begin
      int n;
      do_start();
      n = $urandom_range(1, DEPTH + 3);
      for (int i = 0; i < n; i++) begin
        if (m_mode != 1) break;
        send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 1), rand_imm(), (i == n - 1) && ($urandom_range(0, 1) == 1));
      end
      settle();
      check_status("rand");
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
